// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-capable arbiter sharing one FIFO push port among NUM_REQ producers.
// Optional per-requester transfer counters are compiled in with FIFO_PUSH_ARBITER_STATS_EN.
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = $clog2(NUM_REQ),
    parameter int BURST_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]            req_grant_out,
    output logic                          fifo_push_valid_out,
    input  logic                          fifo_push_grant_in,
    output logic [DATA_WIDTH-1:0]         fifo_data_out,
    output logic [IDX_W-1:0]              arb_idx_out,
    output logic                          arb_locked_out
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    ,
    input  logic                          clr_stats_in,
    output logic [NUM_REQ*16-1:0]         xfer_cnt_out
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [BURST_W-1:0] burst_cnt, cnt_nxt, cnt_inc;
    logic [IDX_W-1:0]   sel, sel_rr;
    logic               xfer;

    // Explicit wrap so non-power-of-2 NUM_REQ never produces an out-of-range index.
    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    always_comb begin
        int j;
        logic found;
        sel_rr = rr_ptr;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid_in[j]) begin
                sel_rr = IDX_W'(j);
                found  = 1'b1;
            end
        end
    end

    assign sel                 = (state == LOCKED) ? owner : sel_rr;
    assign fifo_push_valid_out = req_valid_in[sel];
    assign fifo_data_out       = fifo_push_valid_out ?
                                 req_data_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign xfer                = fifo_push_valid_out && fifo_push_grant_in;
    assign req_grant_out       = xfer ? (NUM_REQ'(1) << sel) : '0;
    assign arb_idx_out         = sel;
    assign arb_locked_out      = (state == LOCKED);
    assign cnt_inc             = burst_cnt + BURST_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        cnt_nxt   = burst_cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (MAX_BURST == 1) begin
                        rr_nxt = inc_idx(sel);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = sel;
                        cnt_nxt   = BURST_W'(1);
                    end
                end
            end
            LOCKED: begin
                // Owner withdrawing costs one bubble cycle; backpressure alone holds everything.
                if (!req_valid_in[owner]) begin
                    state_nxt = IDLE;
                    rr_nxt    = inc_idx(owner);
                    cnt_nxt   = '0;
                end else if (xfer) begin
                    if (cnt_inc == BURST_W'(MAX_BURST)) begin
                        state_nxt = IDLE;
                        rr_nxt    = inc_idx(owner);
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (clr_stats_in)
                cnt <= '0;
            else if (req_grant_out[g] && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign xfer_cnt_out[g*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: per-cycle expectations go through a scoreboard queue
// and are popped and compared on the falling edge.
module tb_fifo_push_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int IDX_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_grant;
    logic                  push_valid;
    logic                  push_grant;
    logic [DW-1:0]         fifo_data;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_locked;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    logic                  clr_stats;
    logic [NUM_REQ*16-1:0] xfer_cnt;
`endif

    typedef struct {
        logic [NUM_REQ-1:0] gnt;
        logic               lock;
        logic [IDX_W-1:0]   idx;
        logic               pv;
        logic [DW-1:0]      data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    fifo_push_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid_in        (req_valid),
        .req_data_in         (req_data),
        .req_grant_out       (req_grant),
        .fifo_push_valid_out (push_valid),
        .fifo_push_grant_in  (push_grant),
        .fifo_data_out       (fifo_data),
        .arb_idx_out         (arb_idx),
        .arb_locked_out      (arb_locked)
`ifdef FIFO_PUSH_ARBITER_STATS_EN
        ,
        .clr_stats_in        (clr_stats),
        .xfer_cnt_out        (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input logic [IDX_W-1:0] i);
        return 8'hA0 + 8'h11 * DW'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, queue what the arbiter must show, compare mid-cycle.
    task automatic cyc(input string tag, input logic [3:0] v, input logic g,
                       input logic [3:0] eg, input logic el, input logic [1:0] ei);
        exp_t e;
        req_valid  = v;
        push_grant = g;
        e.gnt  = eg;
        e.lock = el;
        e.idx  = ei;
        e.pv   = v[ei];
        e.data = v[ei] ? dat(ei) : '0;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".grant"}, 32'(req_grant), 32'(e.gnt));
        chk({tag, ".locked"}, 32'(arb_locked), 32'(e.lock));
        chk({tag, ".idx"}, 32'(arb_idx), 32'(e.idx));
        chk({tag, ".pvalid"}, 32'(push_valid), 32'(e.pv));
        chk({tag, ".data"}, 32'(fifo_data), 32'(e.data));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        push_grant = 1'b1;
        req_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
`ifdef FIFO_PUSH_ARBITER_STATS_EN
        clr_stats  = 1'b0;
`endif
        #1;
        cyc("rst", 4'h0, 1'b1, 4'h0, 1'b0, 2'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc("idle", 4'h0, 1'b1, 4'h0, 1'b0, 2'd0);

        // Lone requester 2: two full bursts back to back, then rr_ptr lands on 3.
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 4; k++) cyc("solo2", 4'b0100, 1'b1, 4'b0100, k != 0, 2'd2);
        cyc("solo2_rr", 4'h0, 1'b1, 4'h0, 1'b0, 2'd3);

        rst_n = 1'b0;
        cyc("rst2", 4'h0, 1'b1, 4'h0, 1'b0, 2'd0);
        rst_n = 1'b1;

        // Everyone valid: bursts of four rotating 0,1,2,3,0.
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 4; k++)
                cyc("all", 4'hF, 1'b1, 4'(1 << (b % 4)), k != 0, 2'(b % 4));

        // Req 1 stalls mid-burst under backpressure, then finishes its four.
        cyc("bp_a", 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd1);
        cyc("bp_b", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
        for (int i = 0; i < 5; i++) cyc("bp_hold", 4'b0010, 1'b0, 4'h0, 1'b1, 2'd1);
        cyc("bp_c", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
        cyc("bp_d", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
        cyc("bp_rr", 4'h0, 1'b1, 4'h0, 1'b0, 2'd2);

        // Owner 3 withdraws: bubble cycle, pointer wraps to 0.
        cyc("drop_a", 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd3);
        cyc("drop_b", 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3);
        cyc("bubble", 4'b0001, 1'b1, 4'h0, 1'b1, 2'd3);
        cyc("wrap0", 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0);
        cyc("burst0", 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);

        // Reset lands mid-burst between clock edges; lock must fall without a clock.
        rst_n = 1'b0;
        cyc("rst_mid", 4'h0, 1'b1, 4'h0, 1'b0, 2'd0);
`ifdef FIFO_PUSH_ARBITER_STATS_EN
        chk("stats_zero", 32'(xfer_cnt != '0), 32'd0);
`endif
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc("restart", 4'hF, 1'b1, 4'b0001, k != 0, 2'd0);
        cyc("restart_next", 4'hF, 1'b1, 4'b0010, 1'b0, 2'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin, burst-capable arbiter that lets NUM_REQ producers share the single push port of one FIFO.
- Sits between the producers and the FIFO push side: drives the FIFO's push_valid/data and consumes the FIFO's push_grant.
- Fans the grant back to exactly one producer per cycle.
- Keeps ownership for up to MAX_BURST consecutive transfers to reduce interleaving, then rotates priority.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- DATA_WIDTH, 8, width of each producer's data word.
- MAX_BURST, 4, maximum consecutive transfers per ownership (>=1).
- IDX_W, $clog2(NUM_REQ), width of requester indices (derived).
- BURST_W, $clog2(MAX_BURST+1), width of the burst counter (derived).

Ports:
- clk  input  1  clock, all state updated on rising edge.
- rst_n  input  1  reset: asynchronous, active-low.
- req_valid_in  input  NUM_REQ  per-producer push request.
- req_data_in  input  NUM_REQ*DATA_WIDTH  packed producer data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_grant_out  output  NUM_REQ  one-hot (or zero) transfer acknowledge to producers.
- fifo_push_valid_out  output  1  push request to the FIFO.
- fifo_push_grant_in  input  1  FIFO not-full indication (Moore, registered in the FIFO).
- fifo_data_out  output  DATA_WIDTH  data presented to the FIFO write port.
- arb_idx_out  output  IDX_W  currently selected requester.
- arb_locked_out  output  1  high while in LOCKED state.

Behaviour:
- Transfer: a transfer occurs in a cycle where fifo_push_valid_out && fifo_push_grant_in. Producer rule: once req_valid_in[i] is asserted it is held, with stable data, until req_grant_out[i].
- Registers:
  - state in {IDLE, LOCKED}.
  - rr_ptr[IDX_W], owner[IDX_W], burst_cnt[BURST_W].
  - Reset values: IDLE, 0, 0, 0, applied asynchronously when rst_n is low.
- Selection (combinational, no dependence on fifo_push_grant_in):
  - IDLE: sel = first i with req_valid_in[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ. If none is valid, sel = rr_ptr.
  - LOCKED: sel = owner.
- Outputs (combinational, zero latency):
  - fifo_push_valid_out = req_valid_in[sel].
  - fifo_data_out = req_data_in[sel] when fifo_push_valid_out, else '0.
  - req_grant_out[i] = (i==sel) && fifo_push_valid_out && fifo_push_grant_in.
  - arb_idx_out = sel; arb_locked_out = (state==LOCKED).
  - After reset with no requests, all outputs are 0.
- IDLE transitions:
  - Transfer and MAX_BURST==1: stay IDLE, rr_ptr <= sel+1 mod NUM_REQ.
  - Transfer and MAX_BURST>1: go LOCKED, owner <= sel, burst_cnt <= 1.
  - No transfer (no valid, or FIFO full): stay IDLE, rr_ptr unchanged.
- LOCKED transitions:
  - Transfer and burst_cnt+1==MAX_BURST: go IDLE, rr_ptr <= owner+1 mod NUM_REQ, burst_cnt <= 0.
  - Transfer otherwise: burst_cnt <= burst_cnt+1.
  - Owner valid high but FIFO full: hold all state; ownership is kept through backpressure.
  - Owner valid low: go IDLE, rr_ptr <= owner+1 mod NUM_REQ, burst_cnt <= 0. This is a one-cycle bubble: no transfer occurs that cycle, even if others are valid.
- Wrap-around: index increments wrap explicitly at NUM_REQ, so non-power-of-2 NUM_REQ is legal.
- Fairness bound: with the FIFO never full, a continuously valid requester is granted within (NUM_REQ-1)*(MAX_BURST+1)+1 cycles.
- Reset mid-operation: a burst is abandoned immediately. Grants drop combinationally with state, and no partial count survives.

Optional Feature:
- Macro: FIFO_PUSH_ARBITER_STATS_EN.
- When defined:
  - Adds output port xfer_cnt_out, NUM_REQ*16 bits: per-requester transfer counters, requester i in bits [i*16 +: 16].
  - Counter i increments on each cycle where req_grant_out[i]=1 and saturates at 16'hFFFF.
  - All counters reset to 0.
  - Adds input clr_stats_in, 1 bit: synchronously clears all counters. Clear takes priority over a same-cycle increment.
- When undefined: neither port nor counters exist, and arbitration behaviour is identical.

Test Plan:
- Reset, all valid=0, grant=1 -> all outputs 0, arb_idx_out=0; no state change over 10 cycles.
- NUM_REQ=4, MAX_BURST=4, only req 2 valid continuously, grant=1 -> req_grant_out=4'b0100 for 4 cycles with arb_locked_out=1 on cycles 2-4, one IDLE re-arbitration, then req 2 regranted.
- All 4 valid continuously, grant=1 -> bursts of 4 in order 0,1,2,3,0. fifo_data_out matches each owner's data; exactly one grant bit per cycle.
- Req 1 owns burst (burst_cnt=2), grant=0 for 5 cycles -> req_grant_out=0, owner=1 held, burst_cnt=2 held. When grant returns, 2 more transfers from req 1, then rr_ptr=2.
- Req 3 locked, then drops valid while req 0 valid -> one bubble cycle, IDLE, rr_ptr=0 (wrap from 3), req 0 granted the next cycle.
- Assert rst_n=0 mid-burst -> arb_locked_out and req_grant_out go 0 immediately; after release, arbitration restarts from requester 0. With FIFO_PUSH_ARBITER_STATS_EN defined, all xfer_cnt_out fields read 0.
